sim_run_ctrl: RTL

//  Run controller between the clock/reset source and the processor under test.

---
 rtl/sim_run_ctrl_if.sv | 24 ++
 rtl/sim_run_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/sim_run_ctrl_if.sv
// Signal bundle between the run controller and the processor-under-test harness.
// The master side reports err/halt/clr; the slave side (controller) drives reset and status.
interface sim_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             err;
  logic             halt;
  logic             clr;
  logic             sys_rst;
  logic             run;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       status;
  logic             stop;

  modport master (
    output err, halt, clr,
    input  sys_rst, run, cycle_count, status, stop
  );

  modport slave (
    input  err, halt, clr,
    output sys_rst, run, cycle_count, status, stop
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller: synchronised reset release, timed core-reset hold, RUN watchdog,
// and sticky terminal states that pulse stop on entry.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   HOLD    | core held in reset; counting HOLD_CYCLES once sync is high
//   RUN     | core running; cycle_count advances, err/halt/limit watched
//   DONE    | core reported halt
//   ERROR   | core reported err (wins over halt)
//   TIMEOUT | cycle_count reached MAX_CYCLES without err/halt
module sim_run_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int MAX_CYCLES  = 100000,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         rst_n,
  sim_run_ctrl_if.slave bus
);

  localparam logic [2:0] S_HOLD    = 3'b000;
  localparam logic [2:0] S_RUN     = 3'b001;
  localparam logic [2:0] S_DONE    = 3'b010;
  localparam logic [2:0] S_ERROR   = 3'b011;
  localparam logic [2:0] S_TIMEOUT = 3'b100;

  localparam int               HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_q1, sync_q2;
  logic [2:0]       state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stop_q, stop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= 1'b1;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    count_d    = count_q;
    case (state_q)
      S_HOLD: begin
        if (sync_q2) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
          if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.err)                state_d = S_ERROR;
        else if (bus.halt)          state_d = S_DONE;
        else if (count_q == CNT_MAX) state_d = S_TIMEOUT;
        else                        count_d = count_q + CNT_ONE;
      end
      S_DONE, S_ERROR, S_TIMEOUT: begin
        // sync stays high here, so a restart is re-timed by the hold count alone
        if (bus.clr) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
          count_d    = '0;
        end
      end
      default: begin
        state_d    = S_HOLD;
        hold_cnt_d = '0;
        count_d    = '0;
      end
    endcase
  end

  // RUN can only exit into a terminal state, so any exit from RUN is a terminal entry
  assign stop_d = (state_q == S_RUN) && (state_d != S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      count_q    <= '0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      count_q    <= count_d;
      stop_q     <= stop_d;
    end
  end

  assign bus.sys_rst     = !((state_q == S_RUN) || (state_q == S_DONE) ||
                             (state_q == S_ERROR) || (state_q == S_TIMEOUT));
  assign bus.run         = (state_q == S_RUN);
  assign bus.status      = state_q;
  assign bus.cycle_count = count_q;
  assign bus.stop        = stop_q;

endmodule
